writeback_stage: RTL and testbench

Final pipeline stage, directly downstream of the two-stage execution unit. It consumes the registered execution result, valid, PC and instruction, and commits the result to the integer register file (x0 hardwired to zero). It provides two bypassed combinational read ports to decode, a one-entry hold buffer that absorbs results arriving during system_stall, and retire trace outputs with a 64-bit instret counter.

---
 rtl/writeback_stage.sv | 189 ++++++++++++++++++
 tb/tb_writeback_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Purpose : final pipeline stage; commits execution results to the integer register file (x0 = 0),
//           serves two bypassed read ports to decode, and emits retire trace plus a 64-bit instret.
// Latency : a valid result with no stall is visible in the RF and on retire_* one cycle later.
// Backpr. : no ready; during system_stall one result is parked in a hold buffer, and a second result is
//           dropped and latches wb_overflow until reset.
// Ports   : clk/reset (sync, active-high); system_stall; wb_valid_in/result/pc/instruction from execution;
//           rs1/rs2 addr->data (combinational, youngest-first bypass); retire_* pulse, instret_count,
//           and wb_overflow.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_stall,
    input  logic                  wb_valid_in,
    input  logic [DATA_WIDTH-1:0] wb_result_in,
    input  logic [ADDR_WIDTH-1:0] wb_pc_in,
    input  logic [INST_WIDTH-1:0] wb_instruction_in,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  retire_valid,
    output logic [ADDR_WIDTH-1:0] retire_pc,
    output logic [INST_WIDTH-1:0] retire_instruction,
    output logic [4:0]            retire_rd,
    output logic [DATA_WIDTH-1:0] retire_data,
    output logic [63:0]           instret_count,
    output logic                  wb_overflow
);

    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];

    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_result_q, hold_result_d;
    logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;

    logic                  retire_valid_q, retire_valid_d;
    logic [ADDR_WIDTH-1:0] retire_pc_q, retire_pc_d;
    logic [INST_WIDTH-1:0] retire_inst_q, retire_inst_d;
    logic [4:0]            retire_rd_q, retire_rd_d;
    logic [DATA_WIDTH-1:0] retire_data_q, retire_data_d;
    logic [63:0]           instret_q, instret_d;
    logic                  overflow_q, overflow_d;

    logic                  commit_vld;
    logic [4:0]            commit_rd;
    logic [DATA_WIDTH-1:0] commit_dat;
    logic [ADDR_WIDTH-1:0] commit_pc;
    logic [INST_WIDTH-1:0] commit_inst;

    logic [4:0] in_rd;
    logic [4:0] hold_rd;
    assign in_rd   = wb_instruction_in[11:7];
    assign hold_rd = hold_inst_q[11:7];

    always_comb begin
        rf_d           = rf_q;
        hold_valid_d   = hold_valid_q;
        hold_result_d  = hold_result_q;
        hold_pc_d      = hold_pc_q;
        hold_inst_d    = hold_inst_q;
        retire_pc_d    = retire_pc_q;
        retire_inst_d  = retire_inst_q;
        retire_rd_d    = retire_rd_q;
        retire_data_d  = retire_data_q;
        instret_d      = instret_q;
        overflow_d     = overflow_q;
        commit_vld     = 1'b0;
        commit_rd      = '0;
        commit_dat     = '0;
        commit_pc      = '0;
        commit_inst    = '0;

        if (system_stall) begin
            if (wb_valid_in) begin
                if (!hold_valid_q) begin
                    hold_valid_d  = 1'b1;
                    hold_result_d = wb_result_in;
                    hold_pc_d     = wb_pc_in;
                    hold_inst_d   = wb_instruction_in;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (hold_valid_q) begin
            // Oldest first: drain the hold entry; a same-cycle input takes its place.
            commit_vld   = 1'b1;
            commit_rd    = hold_rd;
            commit_dat   = hold_result_q;
            commit_pc    = hold_pc_q;
            commit_inst  = hold_inst_q;
            hold_valid_d = wb_valid_in;
            if (wb_valid_in) begin
                hold_result_d = wb_result_in;
                hold_pc_d     = wb_pc_in;
                hold_inst_d   = wb_instruction_in;
            end
        end else if (wb_valid_in) begin
            commit_vld  = 1'b1;
            commit_rd   = in_rd;
            commit_dat  = wb_result_in;
            commit_pc   = wb_pc_in;
            commit_inst = wb_instruction_in;
        end

        retire_valid_d = commit_vld;
        if (commit_vld) begin
            if (commit_rd != 5'd0) begin
                rf_d[commit_rd] = commit_dat;
            end
            retire_pc_d   = commit_pc;
            retire_inst_d = commit_inst;
            retire_rd_d   = commit_rd;
            retire_data_d = commit_dat;
            instret_d     = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            hold_valid_q   <= 1'b0;
            hold_result_q  <= '0;
            hold_pc_q      <= '0;
            hold_inst_q    <= '0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_inst_q  <= '0;
            retire_rd_q    <= '0;
            retire_data_q  <= '0;
            instret_q      <= '0;
            overflow_q     <= 1'b0;
        end else begin
            rf_q           <= rf_d;
            hold_valid_q   <= hold_valid_d;
            hold_result_q  <= hold_result_d;
            hold_pc_q      <= hold_pc_d;
            hold_inst_q    <= hold_inst_d;
            retire_valid_q <= retire_valid_d;
            retire_pc_q    <= retire_pc_d;
            retire_inst_q  <= retire_inst_d;
            retire_rd_q    <= retire_rd_d;
            retire_data_q  <= retire_data_d;
            instret_q      <= instret_d;
            overflow_q     <= overflow_d;
        end
    end

    // Youngest value wins: live input, then hold entry, then architectural state.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [4:0]            idx,
        input logic                  in_vld,
        input logic [4:0]            in_idx,
        input logic [DATA_WIDTH-1:0] in_dat,
        input logic                  h_vld,
        input logic [4:0]            h_idx,
        input logic [DATA_WIDTH-1:0] h_dat,
        input logic [DATA_WIDTH-1:0] rf_val
    );
        logic [DATA_WIDTH-1:0] r;
        if (idx == 5'd0)                      r = '0;
        else if (in_vld && (in_idx == idx))   r = in_dat;
        else if (h_vld && (h_idx == idx))     r = h_dat;
        else                                  r = rf_val;
        return r;
    endfunction

    assign rs1_data = read_port(rs1_addr, wb_valid_in, in_rd, wb_result_in,
                                hold_valid_q, hold_rd, hold_result_q, rf_q[rs1_addr]);
    assign rs2_data = read_port(rs2_addr, wb_valid_in, in_rd, wb_result_in,
                                hold_valid_q, hold_rd, hold_result_q, rf_q[rs2_addr]);

    assign retire_valid       = retire_valid_q;
    assign retire_pc          = retire_pc_q;
    assign retire_instruction = retire_inst_q;
    assign retire_rd          = retire_rd_q;
    assign retire_data        = retire_data_q;
    assign instret_count      = instret_q;
    assign wb_overflow        = overflow_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Purpose : self-checking bench for writeback_stage using a directed vector table plus stall/bypass/overflow sequences.
// Latency : checks retire_* and RF one cycle after each commit edge; read ports checked combinationally.
// Backpr. : exercises system_stall hold buffering and the sticky overflow on a second stalled result.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        system_stall;
    logic        wb_valid_in;
    logic [31:0] wb_result_in;
    logic [31:0] wb_pc_in;
    logic [31:0] wb_instruction_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instruction;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic [63:0] instret_count;
    logic        wb_overflow;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                (clk),
        .reset              (reset),
        .system_stall       (system_stall),
        .wb_valid_in        (wb_valid_in),
        .wb_result_in       (wb_result_in),
        .wb_pc_in           (wb_pc_in),
        .wb_instruction_in  (wb_instruction_in),
        .rs1_addr           (rs1_addr),
        .rs2_addr           (rs2_addr),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .retire_valid       (retire_valid),
        .retire_pc          (retire_pc),
        .retire_instruction (retire_instruction),
        .retire_rd          (retire_rd),
        .retire_data        (retire_data),
        .instret_count      (instret_count),
        .wb_overflow        (wb_overflow)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] exp_read;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
        wb_valid_in       = vld;
        wb_result_in      = res;
        wb_pc_in          = pc;
        wb_instruction_in = {20'd0, rd, 7'b0110011};
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{rd: 5'd5,  result: 32'hDEADBEEF, pc: 32'h100, exp_read: 32'hDEADBEEF};
        vecs[1] = '{rd: 5'd0,  result: 32'h00001234, pc: 32'h104, exp_read: 32'h0};
        vecs[2] = '{rd: 5'd31, result: 32'hFFFFFFFF, pc: 32'h108, exp_read: 32'hFFFFFFFF};
        vecs[3] = '{rd: 5'd1,  result: 32'h00000001, pc: 32'h10C, exp_read: 32'h1};
        vecs[4] = '{rd: 5'd5,  result: 32'hCAFEF00D, pc: 32'h110, exp_read: 32'hCAFEF00D};

        reset = 1'b1; system_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        tick(); tick();
        reset = 1'b0;
        exp_instret = 64'd0;

        // Reset state
        check("reset_retire_valid", {63'd0, retire_valid}, 64'd0);
        check("reset_instret", instret_count, 64'd0);
        check("reset_overflow", {63'd0, wb_overflow}, 64'd0);
        rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
        check("reset_rs1", {32'd0, rs1_data}, 64'd0);
        check("reset_rs2", {32'd0, rs2_data}, 64'd0);

        // Vector table: one commit per entry, no stall
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].rd, vecs[i].result, vecs[i].pc);
            tick();
            drive(1'b0, 5'd0, 32'd0, 32'd0);
            rs1_addr = vecs[i].rd;
            exp_instret++;
            #1;
            check("vec_retire_valid", {63'd0, retire_valid}, 64'd1);
            check("vec_retire_rd", {59'd0, retire_rd}, {59'd0, vecs[i].rd});
            check("vec_retire_pc", {32'd0, retire_pc}, {32'd0, vecs[i].pc});
            check("vec_retire_data", {32'd0, retire_data}, {32'd0, vecs[i].result});
            check("vec_rs1_read", {32'd0, rs1_data}, {32'd0, vecs[i].exp_read});
            check("vec_instret", instret_count, exp_instret);
        end
        tick();
        check("idle_retire_valid", {63'd0, retire_valid}, 64'd0);
        rs1_addr = 5'd31; rs2_addr = 5'd1; #1;
        check("rf_keep_r31", {32'd0, rs1_data}, 64'hFFFFFFFF);
        check("rf_keep_r1", {32'd0, rs2_data}, 64'h1);

        // Bypass from live input, both ports same register
        drive(1'b1, 5'd7, 32'h55, 32'h180);
        rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
        check("bypass_in_rs2", {32'd0, rs2_data}, 64'h55);
        check("bypass_in_rs1", {32'd0, rs1_data}, 64'h55);
        // Park it in the hold buffer under stall
        system_stall = 1'b1;
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0); #1;
        check("stall_no_retire", {63'd0, retire_valid}, 64'd0);
        check("bypass_hold", {32'd0, rs1_data}, 64'h55);
        drive(1'b1, 5'd7, 32'h77, 32'h184); #1;
        check("bypass_in_over_hold", {32'd0, rs2_data}, 64'h77);
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        system_stall = 1'b0;
        tick();
        exp_instret++;
        check("hold_commit_valid", {63'd0, retire_valid}, 64'd1);
        check("hold_commit_rd", {59'd0, retire_rd}, 64'd7);
        check("hold_commit_data", {32'd0, retire_data}, 64'h55);
        check("hold_commit_rf", {32'd0, rs1_data}, 64'h55);
        check("hold_commit_instret", instret_count, exp_instret);

        // Stall buffering: rd3 held, then rd4 arrives as the hold drains
        system_stall = 1'b1;
        drive(1'b1, 5'd3, 32'hA, 32'h200);
        tick();
        system_stall = 1'b0;
        drive(1'b1, 5'd4, 32'hB, 32'h204);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        exp_instret++;
        check("order1_rd", {59'd0, retire_rd}, 64'd3);
        check("order1_pc", {32'd0, retire_pc}, 64'h200);
        tick();
        exp_instret++;
        rs1_addr = 5'd3; rs2_addr = 5'd4; #1;
        check("order2_valid", {63'd0, retire_valid}, 64'd1);
        check("order2_rd", {59'd0, retire_rd}, 64'd4);
        check("order2_pc", {32'd0, retire_pc}, 64'h204);
        check("order_rf_r3", {32'd0, rs1_data}, 64'hA);
        check("order_rf_r4", {32'd0, rs2_data}, 64'hB);
        check("order_instret", instret_count, exp_instret);
        check("order_no_overflow", {63'd0, wb_overflow}, 64'd0);

        // Overflow: two results during one stall
        system_stall = 1'b1;
        drive(1'b1, 5'd8, 32'h1, 32'h300);
        tick();
        drive(1'b1, 5'd9, 32'h2, 32'h304);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        check("ovf_set", {63'd0, wb_overflow}, 64'd1);
        system_stall = 1'b0;
        tick();
        exp_instret++;
        rs1_addr = 5'd8; rs2_addr = 5'd9; #1;
        check("ovf_commit_rd", {59'd0, retire_rd}, 64'd8);
        check("ovf_r8", {32'd0, rs1_data}, 64'h1);
        check("ovf_r9_dropped", {32'd0, rs2_data}, 64'h0);
        tick();
        check("ovf_single_commit", {63'd0, retire_valid}, 64'd0);
        check("ovf_instret", instret_count, exp_instret);
        check("ovf_sticky", {63'd0, wb_overflow}, 64'd1);

        // Reset mid-stall discards the held entry and clears all state
        system_stall = 1'b1;
        drive(1'b1, 5'd10, 32'h99, 32'h400);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; system_stall = 1'b0;
        tick();
        rs1_addr = 5'd10; rs2_addr = 5'd5; #1;
        check("rst2_no_retire", {63'd0, retire_valid}, 64'd0);
        check("rst2_hold_gone", {32'd0, rs1_data}, 64'h0);
        check("rst2_rf_clear", {32'd0, rs2_data}, 64'h0);
        check("rst2_instret", instret_count, 64'd0);
        check("rst2_overflow", {63'd0, wb_overflow}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
